// File: rtl/hazard_unit_if.sv
// Pipeline-side signal bundle for hazard_unit: hazard detection inputs and
// the stall/flush/enable controls it returns to the pipeline registers.
interface hazard_unit_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        mem_branch_taken;
  logic        dmem_busy;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        risk_sig;
  logic        idex_flush;
  logic        exmem_flush;
  logic        pipe_en;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;

  // Pipeline datapath view.
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, mem_branch_taken, dmem_busy,
    input  pc_write, ifid_write, ifid_flush, risk_sig, idex_flush, exmem_flush, pipe_en,
    input  stall_cycles, flush_count
  );

  // Hazard unit view.
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, mem_branch_taken, dmem_busy,
    output pc_write, ifid_write, ifid_flush, risk_sig, idex_flush, exmem_flush, pipe_en,
    output stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_unit.sv
// Load-use stall / branch flush / memory freeze control for a 5-stage pipeline.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_unit #(
  parameter int LOAD_BUBBLES = 1
) (
  input logic         clk,
  input logic         rst_n,
  hazard_unit_if.slave hz
);
  typedef enum logic {RUN, LSTALL} stateT;

  // Bubbles still owed after the first one, loaded when a load-use is detected.
  localparam logic [1:0] RELOAD = 2'(LOAD_BUBBLES - 1);

  stateT      state, nextState;
  logic [1:0] cnt, nextCnt;
  logic       loadUse;

  assign loadUse = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                   ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    hz.pc_write    = 1'b1;
    hz.ifid_write  = 1'b1;
    hz.pipe_en     = 1'b1;
    hz.risk_sig    = 1'b0;
    hz.ifid_flush  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.exmem_flush = 1'b0;
    nextState      = state;
    nextCnt        = cnt;

    if (!rst_n) begin
      // Hold the front end and bubble ID while reset is asserted.
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.risk_sig   = 1'b1;
      nextState     = RUN;
      nextCnt       = 2'd0;
    end else if (hz.dmem_busy) begin
      // Full freeze: nothing advances, pending bubbles are preserved.
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.pipe_en    = 1'b0;
    end else if (hz.mem_branch_taken) begin
      hz.ifid_flush  = 1'b1;
      hz.idex_flush  = 1'b1;
      hz.exmem_flush = 1'b1;
      hz.risk_sig    = 1'b1;
      nextState      = RUN;
      nextCnt        = 2'd0;
    end else if (state == LSTALL) begin
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.risk_sig   = 1'b1;
      nextCnt       = cnt - 2'd1;
      if (cnt == 2'd1) nextState = RUN;
    end else if (loadUse) begin
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.risk_sig   = 1'b1;
      if (LOAD_BUBBLES > 1) begin
        nextState = LSTALL;
        nextCnt   = RELOAD;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic        stallTick, flushTick;
  logic [15:0] stallCnt;
  logic [7:0]  flushCnt;

  assign flushTick = rst_n && !hz.dmem_busy && hz.mem_branch_taken;
  assign stallTick = rst_n && hz.risk_sig && hz.pipe_en && !flushTick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCnt <= 16'd0;
      flushCnt <= 8'd0;
    end else begin
      if (stallTick && (stallCnt != 16'hFFFF)) stallCnt <= stallCnt + 16'd1;
      if (flushTick && (flushCnt != 8'hFF))    flushCnt <= flushCnt + 8'd1;
    end
  end

  assign hz.stall_cycles = stallCnt;
  assign hz.flush_count  = flushCnt;
`else
  assign hz.stall_cycles = 16'd0;
  assign hz.flush_count  = 8'd0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: three instances (LOAD_BUBBLES = 1, 2, 3) share one
// input stream and are compared each cycle against a bubbles-owed model.
module tb_hazard_unit;
`ifdef HAZARD_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] idRs = '0, idRt = '0, exRt = '0;
  logic       idUsesRt = 1'b0, exMemRead = 1'b0, branch = 1'b0, busy = 1'b0;

  always #5 clk = ~clk;

  logic [2:0]  pcWrite, ifidWrite, ifidFlush, riskSig, idexFlush, exmemFlush, pipeEn;
  logic [15:0] stallCycles [3];
  logic [7:0]  flushCount  [3];

  for (genvar g = 0; g < 3; g++) begin : gDut
    hazard_unit_if hif ();
    hazard_unit #(.LOAD_BUBBLES(g + 1)) dut (.clk(clk), .rst_n(rst_n), .hz(hif));
    assign hif.id_rs            = idRs;
    assign hif.id_rt            = idRt;
    assign hif.id_uses_rt       = idUsesRt;
    assign hif.ex_mem_read      = exMemRead;
    assign hif.ex_rt            = exRt;
    assign hif.mem_branch_taken = branch;
    assign hif.dmem_busy        = busy;
    assign pcWrite[g]     = hif.pc_write;
    assign ifidWrite[g]   = hif.ifid_write;
    assign ifidFlush[g]   = hif.ifid_flush;
    assign riskSig[g]     = hif.risk_sig;
    assign idexFlush[g]   = hif.idex_flush;
    assign exmemFlush[g]  = hif.exmem_flush;
    assign pipeEn[g]      = hif.pipe_en;
    assign stallCycles[g] = hif.stall_cycles;
    assign flushCount[g]  = hif.flush_count;
  end

  int assertCount = 0;
  int failCount   = 0;
  bit checking    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instance owes a number of further bubble cycles; perf counts are plain ints.
  int owed [3]       = '{0, 0, 0};
  int stallModel [3] = '{0, 0, 0};
  int flushModel [3] = '{0, 0, 0};

  always @(negedge clk) begin : cmp
    bit lu;
    bit ePc, eIfidW, eFlush, eRisk, ePipe;
    if (checking) begin
      lu = exMemRead && (exRt != 0) && ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
      for (int i = 0; i < 3; i++) begin
        ePc = 1; eIfidW = 1; eFlush = 0; eRisk = 0; ePipe = 1;
        if (!rst_n) begin
          ePc = 0; eIfidW = 0; eRisk = 1;
        end else if (busy) begin
          ePc = 0; eIfidW = 0; ePipe = 0;
        end else if (branch) begin
          eFlush = 1; eRisk = 1;
        end else if (owed[i] > 0 || lu) begin
          ePc = 0; eIfidW = 0; eRisk = 1;
        end
        check($sformatf("pc_write[%0d]", i),    32'(pcWrite[i]),    32'(ePc));
        check($sformatf("ifid_write[%0d]", i),  32'(ifidWrite[i]),  32'(eIfidW));
        check($sformatf("ifid_flush[%0d]", i),  32'(ifidFlush[i]),  32'(eFlush));
        check($sformatf("idex_flush[%0d]", i),  32'(idexFlush[i]),  32'(eFlush));
        check($sformatf("exmem_flush[%0d]", i), 32'(exmemFlush[i]), 32'(eFlush));
        check($sformatf("risk_sig[%0d]", i),    32'(riskSig[i]),    32'(eRisk));
        check($sformatf("pipe_en[%0d]", i),     32'(pipeEn[i]),     32'(ePipe));
        check($sformatf("stall_cycles[%0d]", i), 32'(stallCycles[i]), PERF * stallModel[i]);
        check($sformatf("flush_count[%0d]", i),  32'(flushCount[i]),  PERF * flushModel[i]);
        // Advance the model to the state after the coming edge.
        if (!rst_n) begin
          owed[i] = 0; stallModel[i] = 0; flushModel[i] = 0;
        end else if (busy) begin
          owed[i] = owed[i];
        end else if (branch) begin
          owed[i] = 0;
          if (flushModel[i] < 255) flushModel[i]++;
        end else if (owed[i] > 0 || lu) begin
          owed[i] = (owed[i] > 0) ? owed[i] - 1 : i;
          if (stallModel[i] < 65535) stallModel[i]++;
        end
      end
    end
  end

  // Apply one cycle of inputs just after the edge, return at the following negedge.
  task automatic cyc(input bit r, input bit mr, input logic [4:0] er, input logic [4:0] rs,
                     input logic [4:0] rt, input bit ur, input bit br, input bit bz);
    @(posedge clk);
    #1;
    rst_n = r; exMemRead = mr; exRt = er; idRs = rs; idRt = rt;
    idUsesRt = ur; branch = br; busy = bz;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk);
    #1 checking = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("reset pc_write", 32'(pcWrite), 32'b000);
    check("reset pipe_en",  32'(pipeEn),  32'b111);
    check("reset risk_sig", 32'(riskSig), 32'b111);
    check("reset flush",    32'(ifidFlush | idexFlush | exmemFlush), 32'b000);

    // Load-use on rs, hazard removed after one cycle.
    cyc(1, 1, 8, 8, 0, 0, 0, 0);
    check("lu pc_write",  32'(pcWrite), 32'b000);
    check("lu risk_sig",  32'(riskSig), 32'b111);
    idle();
    check("lu +1 pc_write", 32'(pcWrite), 32'b001);
    idle();
    check("lu +2 pc_write", 32'(pcWrite), 32'b011);
    idle();
    check("lu +3 pc_write", 32'(pcWrite), 32'b111);
    check("stall_cycles lb1", 32'(stallCycles[0]), PERF * 1);
    check("stall_cycles lb2", 32'(stallCycles[1]), PERF * 2);
    check("stall_cycles lb3", 32'(stallCycles[2]), PERF * 3);

    // No hazard: ex_rt is $zero, or rt not used as a source.
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    check("zero reg no stall", 32'(pcWrite), 32'b111);
    cyc(1, 1, 5, 1, 5, 0, 0, 0);
    check("rt unused no stall", 32'(pcWrite), 32'b111);
    cyc(1, 1, 5, 1, 5, 1, 0, 0);
    check("rt used stall", 32'(pcWrite), 32'b000);
    idle(); idle(); idle();

    // Freeze during a pending stall does not consume bubbles.
    cyc(1, 1, 8, 8, 0, 0, 0, 0);
    repeat (4) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 1);
      check("busy pipe_en", 32'(pipeEn), 32'b000);
    end
    idle();
    check("post-busy pc_write", 32'(pcWrite), 32'b001);
    idle();
    check("post-busy +1 pc_write", 32'(pcWrite), 32'b011);
    idle();

    // Branch coincident with load-use, then branch held behind a freeze.
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 8, 8, 0, 0, 1, 0);
    check("br ifid_flush",  32'(ifidFlush),  32'b111);
    check("br idex_flush",  32'(idexFlush),  32'b111);
    check("br exmem_flush", 32'(exmemFlush), 32'b111);
    check("br pc_write",    32'(pcWrite),    32'b111);
    idle();
    check("br then run", 32'(pcWrite), 32'b111);
    check("flush_count 1", 32'(flushCount[0]), PERF * 1);
    cyc(1, 0, 0, 0, 0, 0, 1, 1);
    check("busy+br pipe_en", 32'(pipeEn), 32'b000);
    check("busy+br flush",   32'(ifidFlush), 32'b000);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    check("br after busy flush", 32'(ifidFlush), 32'b111);
    idle();
    check("flush_count 2", 32'(flushCount[2]), PERF * 2);

    // Reset in the middle of a stall.
    cyc(1, 1, 8, 8, 0, 0, 0, 0);
    cyc(0, 1, 8, 8, 0, 0, 0, 0);
    check("rst stall pc_write", 32'(pcWrite), 32'b000);
    check("rst stall pipe_en",  32'(pipeEn),  32'b111);
    check("rst stall risk_sig", 32'(riskSig), 32'b111);
    idle();
    check("post-rst pc_write",     32'(pcWrite), 32'b111);
    check("post-rst stall_cycles", 32'(stallCycles[2]), 0);
    check("post-rst flush_count",  32'(flushCount[2]), 0);

    // Flush counter saturation.
    repeat (260) cyc(1, 0, 0, 0, 0, 0, 1, 0);
    idle();
    check("flush_count sat", 32'(flushCount[1]), PERF * 255);

    // Randomized traffic with small register numbers to provoke hazards.
    repeat (3000) begin
      cyc($urandom_range(99) >= 2, $urandom_range(1),
          5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
          $urandom_range(1), $urandom_range(9) == 0, $urandom_range(4) == 0);
    end

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
